// File: rtl/mem_dp_port_arb.sv
// Two-requester round-robin arbiter with burst hold for RAM port A.
// Grants are combinational; read responses return after RD_LATENCY
// cycles through a {valid, id} pipe that tracks the RAM read latency.
//
// owner     | meaning
// ----------+-----------------------------------------------
// OWN_IDLE  | no grant last cycle; ties go to requester != last
// OWN_R0    | requester 0 granted last cycle; may keep the port
// OWN_R1    | requester 1 granted last cycle; may keep the port
module mem_dp_port_arb #(
  parameter  int MEM_DATAWIDTH = 128,
  parameter  int MEM_ADDRWIDTH = 14,
  parameter  int RD_LATENCY    = 2,
  parameter  int BURST_LEN     = 4,
  localparam int BW            = (MEM_DATAWIDTH + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r0_en,
  input  logic [BW-1:0]            r0_we,
  input  logic [MEM_ADDRWIDTH-1:0] r0_addr,
  input  logic [MEM_DATAWIDTH-1:0] r0_wdata,
  output logic                     r0_stall,
  output logic                     r0_rvalid,
  output logic [MEM_DATAWIDTH-1:0] r0_rdata,
  input  logic                     r1_en,
  input  logic [BW-1:0]            r1_we,
  input  logic [MEM_ADDRWIDTH-1:0] r1_addr,
  input  logic [MEM_DATAWIDTH-1:0] r1_wdata,
  output logic                     r1_stall,
  output logic                     r1_rvalid,
  output logic [MEM_DATAWIDTH-1:0] r1_rdata,
  output logic                     ena,
  output logic [BW-1:0]            wea,
  output logic [MEM_ADDRWIDTH-1:0] addra,
  output logic [MEM_DATAWIDTH-1:0] dina,
  input  logic [MEM_DATAWIDTH-1:0] douta
);

  localparam int            CW      = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN);
  localparam int            LAST    = RD_LATENCY - 1;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  owner_t                r_owner;
  owner_t                w_owner_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_pid;

  logic w_req0;
  logic w_req1;
  logic w_gnt;
  logic w_gnt_id;
  logic w_push;
  logic w_rv;

  // Requests are masked while reset is low so every output reads zero.
  assign w_req0 = r0_en & reset;
  assign w_req1 = r1_en & reset;

  // Grant decision: owner keeps the port until its burst is used up
  // while the other waits; otherwise round-robin on ties.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 1'b0;
    if (r_owner == OWN_R0 && w_req0 && (r_cnt < CNT_MAX || !w_req1)) begin
      w_gnt    = 1'b1;
      w_gnt_id = 1'b0;
    end else if (r_owner == OWN_R1 && w_req1 && (r_cnt < CNT_MAX || !w_req0)) begin
      w_gnt    = 1'b1;
      w_gnt_id = 1'b1;
    end else if (w_req0 ^ w_req1) begin
      w_gnt    = 1'b1;
      w_gnt_id = w_req1;
    end else if (w_req0 && w_req1) begin
      w_gnt = 1'b1;
      case (r_owner)
        OWN_R0:  w_gnt_id = 1'b1;
        OWN_R1:  w_gnt_id = 1'b0;
        default: w_gnt_id = ~r_last;
      endcase
    end
  end

  // Next owner, burst counter and last-granted bookkeeping.
  always_comb begin
    w_owner_nxt = OWN_IDLE;
    w_cnt_nxt   = '0;
    w_last_nxt  = r_last;
    if (w_gnt) begin
      w_owner_nxt = w_gnt_id ? OWN_R1 : OWN_R0;
      w_last_nxt  = w_gnt_id;
      if (r_owner == w_owner_nxt)
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      else
        w_cnt_nxt = CW'(1);
    end
  end

  // Arbitration state register; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // RAM port mux; all-zero when nothing is granted.
  always_comb begin
    ena   = w_gnt;
    wea   = '0;
    addra = '0;
    dina  = '0;
    if (w_gnt) begin
      wea   = w_gnt_id ? r1_we    : r0_we;
      addra = w_gnt_id ? r1_addr  : r0_addr;
      dina  = w_gnt_id ? r1_wdata : r0_wdata;
    end
  end

  assign w_push   = w_gnt && (wea == '0);
  assign r0_stall = w_req0 & ~(w_gnt & ~w_gnt_id);
  assign r1_stall = w_req1 & ~(w_gnt & w_gnt_id);

  // Response pipe mirroring the RAM read latency; cleared on reset so
  // in-flight reads are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv  <= '0;
      r_pid <= '0;
    end else begin
      r_pv[0]  <= w_push;
      r_pid[0] <= w_gnt_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign w_rv      = r_pv[LAST];
  assign r0_rvalid = w_rv & ~r_pid[LAST];
  assign r1_rvalid = w_rv &  r_pid[LAST];
  assign r0_rdata  = r0_rvalid ? douta : '0;
  assign r1_rdata  = r1_rvalid ? douta : '0;

endmodule

// File: tb/tb_mem_dp_port_arb.sv
// Directed bench for mem_dp_port_arb: a RAM model on instance u_dut
// (BURST_LEN=4) and a second instance u_dut1 (BURST_LEN=1) sharing the
// same request inputs for the alternation check.
module tb_mem_dp_port_arb;
  localparam int DW = 128;
  localparam int AW = 14;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_en, r1_en;
  logic [BW-1:0] r0_we, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;

  logic          r0_stall, r1_stall, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          ena;
  logic [BW-1:0] wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina, douta;

  logic          b_r0_stall, b_r1_stall, b_r0_rvalid, b_r1_rvalid;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata;
  logic          b_ena;
  logic [BW-1:0] b_wea;
  logic [AW-1:0] b_addra;
  logic [DW-1:0] b_dina;
  logic [DW-1:0] b_douta;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign b_douta = '0;

  mem_dp_port_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .RD_LATENCY(2), .BURST_LEN(4)) u_dut (
    .clk(clk), .reset(reset),
    .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_stall(r0_stall), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_stall(r1_stall), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
  );

  mem_dp_port_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .RD_LATENCY(2), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_stall(b_r0_stall), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_stall(b_r1_stall), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
    .ena(b_ena), .wea(b_wea), .addra(b_addra), .dina(b_dina), .douta(b_douta)
  );

  // RAM model: 16 words, byte writes, 2-cycle read latency.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_p0, rd_p1;

  function automatic logic [DW-1:0] memval(input int i);
    return {96'h0, 32'hC0DE_0000 | i};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = memval(i);
  end

  always @(posedge clk) begin
    if (ena) begin
      for (int b = 0; b < BW; b++)
        if (wea[b]) mem[addra[3:0]][b*8 +: 8] <= dina[b*8 +: 8];
      rd_p0 <= mem[addra[3:0]];
    end
    rd_p1 <= rd_p0;
  end
  assign douta = rd_p1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_en = 1'b0; r0_we = '0; r0_addr = '0; r0_wdata = '0;
    r1_en = 1'b0; r1_we = '0; r1_addr = '0; r1_wdata = '0;
  endtask

  int ord4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  logic [DW-1:0] d3;
  logic [DW-1:0] da5;
  int id;

  initial begin
    d3  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    da5 = {16{8'hA5}};
    idle_inputs();
    reset = 1'b0;
    r0_en = 1'b1;
    r1_en = 1'b1;
    next_cycle();
    next_cycle();

    // Outputs held at zero during reset even with requests present.
    @(negedge clk);
    check("rst_ena", DW'(ena), DW'(0));
    check("rst_r0_stall", DW'(r0_stall), DW'(0));
    check("rst_r1_stall", DW'(r1_stall), DW'(0));
    check("rst_r0_rvalid", DW'(r0_rvalid), DW'(0));
    next_cycle();

    // Tie from IDLE: r0 writes addr 3, r1 reads addr 3.
    reset = 1'b1;
    r0_en = 1'b1; r0_we = '1; r0_addr = 14'd3; r0_wdata = d3;
    r1_en = 1'b1; r1_we = '0; r1_addr = 14'd3;
    @(negedge clk);
    check("tie_r0_stall", DW'(r0_stall), DW'(0));
    check("tie_r1_stall", DW'(r1_stall), DW'(1));
    check("tie_wea", DW'(wea), DW'(16'hFFFF));
    check("tie_addra", DW'(addra), DW'(3));
    check("tie_dina", dina, d3);
    next_cycle();
    r0_en = 1'b0;
    @(negedge clk);
    check("tie_r1_gnt_stall", DW'(r1_stall), DW'(0));
    check("tie_r1_wea", DW'(wea), DW'(0));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("tie_early_rvalid", DW'(r1_rvalid), DW'(0));
    next_cycle();
    @(negedge clk);
    check("tie_r1_rvalid", DW'(r1_rvalid), DW'(1));
    check("tie_r0_rvalid", DW'(r0_rvalid), DW'(0));
    check("tie_r1_rdata", r1_rdata, d3);
    next_cycle();

    // Single read: write A5 pattern to addr 5, then read it back.
    r0_en = 1'b1; r0_we = '1; r0_addr = 14'd5; r0_wdata = da5;
    next_cycle();
    r0_we = '0;
    @(negedge clk);
    check("rd_stall", DW'(r0_stall), DW'(0));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_t1_rvalid", DW'(r0_rvalid), DW'(0));
    check("rd_t1_rdata", r0_rdata, DW'(0));
    next_cycle();
    @(negedge clk);
    check("rd_t2_rvalid", DW'(r0_rvalid), DW'(1));
    check("rd_t2_rdata", r0_rdata, da5);
    check("rd_t2_r1_rvalid", DW'(r1_rvalid), DW'(0));
    next_cycle();
    @(negedge clk);
    check("rd_t3_rvalid", DW'(r0_rvalid), DW'(0));
    next_cycle();

    // Uncontended burst: ten back-to-back reads of addr 6..15.
    for (int k = 0; k < 12; k++) begin
      r0_en   = (k < 10);
      r0_addr = AW'(6 + k);
      @(negedge clk);
      if (k < 10) check($sformatf("burst_stall_%0d", k), DW'(r0_stall), DW'(0));
      if (k >= 2) begin
        check($sformatf("burst_rvalid_%0d", k), DW'(r0_rvalid), DW'(1));
        check($sformatf("burst_rdata_%0d", k), r0_rdata, memval(6 + k - 2));
      end else begin
        check($sformatf("burst_rvalid_%0d", k), DW'(r0_rvalid), DW'(0));
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();

    // Contention from reset: r0 reads addr 6, r1 reads addr 7.
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 14; k++) begin
      r0_en = (k < 12); r0_addr = 14'd6;
      r1_en = (k < 12); r1_addr = 14'd7;
      @(negedge clk);
      if (k < 12) begin
        check($sformatf("cont_r0_stall_%0d", k), DW'(r0_stall), DW'(ord4[k] != 0));
        check($sformatf("cont_r1_stall_%0d", k), DW'(r1_stall), DW'(ord4[k] != 1));
        check($sformatf("alt_r0_stall_%0d", k), DW'(b_r0_stall), DW'((k % 2) != 0));
        check($sformatf("alt_r1_stall_%0d", k), DW'(b_r1_stall), DW'((k % 2) != 1));
      end
      if (k >= 2) begin
        id = ord4[k-2];
        check($sformatf("cont_r0_rvalid_%0d", k), DW'(r0_rvalid), DW'(id == 0));
        check($sformatf("cont_r1_rvalid_%0d", k), DW'(r1_rvalid), DW'(id == 1));
        check($sformatf("cont_rdata_%0d", k), (id == 0) ? r0_rdata : r1_rdata, memval(6 + id));
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Reset mid-flight: r0 read accepted, reset pulsed before data returns.
    r0_en = 1'b1; r0_addr = 14'd6;
    @(negedge clk);
    check("mid_accept_ena", DW'(ena), DW'(1));
    next_cycle();
    r0_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ena", DW'(ena), DW'(0));
    check("mid_rst_rvalid", DW'(r0_rvalid), DW'(0));
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid_r0_rvalid_%0d", k), DW'(r0_rvalid), DW'(0));
      check($sformatf("mid_r1_rvalid_%0d", k), DW'(r1_rvalid), DW'(0));
      next_cycle();
    end
    r0_en = 1'b1; r0_addr = 14'd9;
    r1_en = 1'b1; r1_addr = 14'd10;
    @(negedge clk);
    check("mid_tie_r0_stall", DW'(r0_stall), DW'(0));
    check("mid_tie_r1_stall", DW'(r1_stall), DW'(1));
    check("mid_tie_addra", DW'(addra), DW'(9));
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dp_port_arb.md
# mem_dp_port_arb

Two-requester arbiter that shares port A of the dual-port memory wrapper between two independent masters, e.g. NoC-side DMA and core-side load/store. It selects one request per cycle with round-robin fairness and a bounded burst hold, drives the RAM port combinationally, and routes read data back to the issuing requester after the fixed RAM read latency. Port B of the memory is not touched by this block.

## Interface
- MEM_DATAWIDTH, 128, RAM data width in bits; byte-enable width BW = (MEM_DATAWIDTH+7)/8
- MEM_ADDRWIDTH, 14, RAM word-address width
- RD_LATENCY, 2, RAM read latency in cycles, from ena to valid douta; range 1..8
- BURST_LEN, 4, maximum consecutive grants to one requester while the other waits; range ≥1
- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-low
- rN_en  input  1  request valid, N ∈ {0,1}
- rN_we  input  BW  byte write enables; all-zero = read
- rN_addr  input  MEM_ADDRWIDTH  word address
- rN_wdata  input  MEM_DATAWIDTH  write data
- rN_stall  output  1  request not accepted this cycle; hold request stable
- rN_rvalid  output  1  read data valid for requester N
- rN_rdata  output  MEM_DATAWIDTH  read data
- ena  output  1  RAM port enable
- wea  output  BW  RAM byte write enables
- addra  output  MEM_ADDRWIDTH  RAM address
- dina  output  MEM_DATAWIDTH  RAM write data
- douta  input  MEM_DATAWIDTH  RAM read data

## Operation
- Registered state:
  - owner ∈ {IDLE, OWN0, OWN1}
  - cnt, saturating at BURST_LEN, width clog2(BURST_LEN+1)
  - last, the most recently granted requester
  - response pipe of RD_LATENCY stages, each stage holding {valid, id}
- Grant decision is combinational, one grant at most per cycle:
  - owner=OWNk, rk_en=1, and (cnt<BURST_LEN or other not requesting) → grant k.
  - Otherwise, if exactly one requester asserts en → grant it.
  - Otherwise, if both assert en → grant the requester ≠ the current owner. When owner=IDLE, grant the requester ≠ last.
- Accepted request g: ena=1, wea/addra/dina = rg fields; rg_stall=0.
- Non-granted requester with en=1: stall=1.
- Requester with en=0: stall=0.
- No grant: ena=0, and wea, addra, dina are all-zero.
- State update:
  - Grant to g with g==previous owner → cnt=min(cnt+1, BURST_LEN).
  - Grant to g with g≠previous owner → cnt=1.
  - Any grant → owner=OWNg, last=g.
  - No grant → owner=IDLE, cnt=0; last is unchanged.
- Read path:
  - An accepted read (wea==0) pushes {1,g} into pipe stage 0; an accepted write or no grant pushes {0,x}.
  - At the last stage, rg_rvalid=1 and rg_rdata=douta; the other requester's rvalid=0.
- Write path: writes produce no response. Acceptance means the write is complete.
- rN_rdata is douta gated by rN_rvalid; it reads zero when not valid.
- No response backpressure: requesters must sink rvalid unconditionally.

## Timing
- Reset asserted (asynchronous) → owner=IDLE, cnt=0, last=1 (requester 0 wins first tie), pipe cleared. While reset is low, all outputs are 0, including stalls.
- Accept to rvalid: exactly RD_LATENCY cycles, so an accept at edge t gives rvalid during cycle t+RD_LATENCY. Sustained throughput is one access per cycle across both requesters.
- Read after write to the same address:
  - Write accepted at cycle t, read accepted at t+1 or later → read returns the new data.
  - Write and read in the same cycle cannot occur, since only one grant is issued per cycle.
- Reset during in-flight reads → those responses are dropped; no rvalid after reset is released.
- The request must stay stable while stall=1. Dropping en while stalled is legal and withdraws the request.
- Fairness bound: a waiting requester is granted within BURST_LEN cycles.

## Test plan
- Single read: r0 writes 0xA5.. to addr 5, then reads addr 5 at cycle t (RD_LATENCY=2) → r0_rvalid=1 at t+2 with r0_rdata=0xA5..; r1_rvalid stays 0.
- Contention: both requesters issue continuous reads from reset, BURST_LEN=4 → grant order 0,0,0,0,1,1,1,1,0…; each stall is high exactly on the non-granted cycles; every read returns to the correct id.
- Uncontended burst: r0 issues 10 back-to-back reads with r1 idle → no stall, ten rvalids on consecutive cycles.
- Tie from IDLE: r0 writes addr 3 and r1 reads addr 3 in the same cycle after reset → r0 granted, r1_stall=1 for one cycle, r1 read returns r0's write data.
- BURST_LEN=1 with both requesters continuous → strict alternation 0,1,0,1.
- Reset mid-flight: read accepted, reset pulsed low for one cycle before RD_LATENCY elapses → no rvalid afterwards; owner=IDLE and r0 wins the next tie.
